// File: rtl/fpga_outq_arbiter_if.sv
// Bundle of channel-side and output-side val/rdy signals around the output-queue arbiter.
// The master modport is the arbiter; the slave modport is the producers plus the enqueue adapter.
interface fpga_outq_arbiter_if #(
  parameter int NUM_CH = 4
) ();
  logic [NUM_CH-1:0]    in_val;
  logic [NUM_CH-1:0]    in_rdy;
  logic [NUM_CH*32-1:0] in_msg;
  logic                 out_val;
  logic                 out_rdy;
  logic [31:0]          out_msg;
  logic [NUM_CH-1:0]    grant;
  logic                 busy;

  modport master (
    input  in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg, grant, busy
  );

  modport slave (
    output in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg, grant, busy
  );
endinterface

// File: rtl/fpga_outq_arbiter.sv
// Round-robin packetizer sharing one 32-bit output among NUM_CH val/rdy channels.
// Each grant emits a header {A5, chan, seq} followed by exactly BURST pass-through data words.
module fpga_outq_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int DATA_SZ = 32,
  parameter int BURST   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  fpga_outq_arbiter_if.master bus
);
  localparam int              PTR_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W:0]  NCH       = (PTR_W+1)'(NUM_CH);
  localparam logic [PTR_W:0]  ONE       = (PTR_W+1)'(1);
  localparam logic [15:0]     LAST_BEAT = 16'(BURST - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   chan_q, chan_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        seq_q, seq_d;

  logic [DATA_SZ-1:0] msg_arr [NUM_CH];
  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W:0]     probe;
  logic [PTR_W:0]     chan_nxt;

  logic [NUM_CH-1:0]  in_rdy_c;
  logic [NUM_CH-1:0]  grant_c;
  logic               out_val_c;
  logic [DATA_SZ-1:0] out_msg_c;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign msg_arr[k] = bus.in_msg[DATA_SZ*k +: DATA_SZ];
  end

  // First valid channel at or after ptr, wrapping modulo NUM_CH.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    probe      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      probe = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (probe >= NCH) probe = probe - NCH;
      if (!pick_found && bus.in_val[probe[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = probe[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    chan_d    = chan_q;
    cnt_d     = cnt_q;
    seq_d     = seq_q;
    in_rdy_c  = '0;
    grant_c   = '0;
    out_val_c = 1'b0;
    out_msg_c = '0;
    chan_nxt  = {1'b0, chan_q} + ONE;
    if (chan_nxt == NCH) chan_nxt = '0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          chan_d  = pick_idx;
          cnt_d   = '0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        grant_c[chan_q] = 1'b1;
        out_val_c       = 1'b1;
        out_msg_c       = {8'hA5, 8'(chan_q), seq_q};
        if (bus.out_rdy) state_d = S_DATA;
      end
      S_DATA: begin
        grant_c[chan_q]  = 1'b1;
        out_val_c        = bus.in_val[chan_q];
        out_msg_c        = msg_arr[chan_q];
        in_rdy_c[chan_q] = bus.out_rdy;
        if (bus.in_val[chan_q] && bus.out_rdy) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == LAST_BEAT) begin
            state_d = S_IDLE;
            ptr_d   = chan_nxt[PTR_W-1:0];
            seq_d   = seq_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      chan_q  <= '0;
      cnt_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
    end
  end

  assign bus.in_rdy  = in_rdy_c;
  assign bus.grant   = grant_c;
  assign bus.out_val = out_val_c;
  assign bus.out_msg = out_msg_c;
  assign bus.busy    = (state_q != S_IDLE);
endmodule

// File: doc/fpga_outq_arbiter.md
# fpga_outq_arbiter

Round-robin packetizing arbiter that shares the single 32-bit output path to the host between several DUT result streams. It sits between up to `NUM_CH` val/rdy producers (each typically an asynch-to-val/rdy adapter output) and the val/rdy-to-xfifo enqueue adapter feeding the output XFIFO. Each grant emits one header word identifying the channel, followed by exactly `BURST` data words from that channel. The host software can therefore demultiplex the stream without sideband signals.

## Interface
- `NUM_CH`, default 4: number of requesting channels, legal range 2..8.
- `DATA_SZ`, default 32: message width; fixed at 32 because of the header format.
- `BURST`, default 4: data words per grant, legal range 1..65535.

Ports:
- `clk` in 1: single clock; all state is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_val` in `NUM_CH`: per-channel valid.
- `in_rdy` out `NUM_CH`: per-channel ready.
- `in_msg` in `NUM_CH*32`: channel k occupies bits [32k+31:32k].
- `out_val` out 1: valid toward the enqueue adapter.
- `out_rdy` in 1: ready from the enqueue adapter.
- `out_msg` out 32: header or data word.
- `grant` out `NUM_CH`: one-hot granted channel; all zero when idle. Debug/scope use.
- `busy` out 1: high in HDR or DATA.

## Operation
- FSM states are IDLE, HDR and DATA.
- Registered state: `ptr` (priority pointer, `clog2(NUM_CH)` bits), `chan` (granted channel), `cnt` (16-bit beat counter), `seq` (16-bit packet sequence number).

IDLE:
- All `in_rdy` are 0 and `out_val` is 0.
- If any `in_val` is high, select the first asserted channel searching ptr, ptr+1, … modulo `NUM_CH`.
- Latch it into `chan`, clear `cnt`, and move to HDR.
- Arbitration uses only `in_val`; no data is consumed in IDLE.

HDR:
- `out_val` = 1.
- `out_msg` = {8'hA5, 8'(chan) zero-extended, seq}, driven from registers.
- All `in_rdy` are 0.
- On `out_rdy`, move to DATA.

DATA:
- Pass-through: `out_val` = `in_val[chan]`, `out_msg` = `in_msg[chan]`, `in_rdy[chan]` = `out_rdy`. All other `in_rdy` are 0.
- Each cycle with `in_val[chan]` and `out_rdy` high is one beat and increments `cnt`.
- On the beat where `cnt` == BURST-1:
  - go to IDLE;
  - set `ptr` to (chan+1) mod `NUM_CH`;
  - set `seq` to seq+1, wrapping 0xFFFF→0x0000.
- Grant is held for the whole burst. If the channel drops `in_val`, `out_val` drops and the arbiter waits indefinitely. No timeout, no preemption.

Other rules:
- `in_val` of non-granted channels has no effect outside IDLE. Those channels see `in_rdy` = 0.
- `grant` = one-hot(chan) in HDR/DATA, 0 in IDLE. `busy` = (state != IDLE).

Boundary conditions:
- Only one channel requesting: it is granted back-to-back. Each of its packets is preceded by IDLE, so there is a one-cycle bubble between packets.
- `BURST` = 1: HDR is followed by exactly one data beat.
- `reset_n` low at any time forces IDLE immediately (asynchronously). Any partial packet is abandoned and not completed. The host detects this as a truncated packet, and it is the host's responsibility.
- An `out_rdy` toggle during HDR holds the header stable until it is accepted.

## Timing
Reset values:
- state = IDLE; `ptr` = 0; `chan` = 0; `cnt` = 0; `seq` = 0.
- Outputs are all 0: `in_rdy`, `out_val`, `grant`, `busy`.
- `out_msg` = 0 while idle.

Latency and throughput:
- A request seen in IDLE on cycle t produces the header with `out_val` = 1 on cycle t+1.
- The first data beat can occur at t+2 if `out_rdy` stays high.
- Minimum packet time is 1 (arbitrate) + 1 (header) + `BURST` cycles.
- Data path in DATA is combinational in→out: zero added latency, no buffering.

Handshake rules:
- `out_val` never depends combinationally on `out_rdy`.
- `in_rdy[chan]` depends combinationally on `out_rdy` in DATA only.
- `out_msg` is stable while `out_val` && !`out_rdy` in HDR. In DATA, stability is the producer's obligation.

## Test plan
- **Single channel.** `NUM_CH`=4, `BURST`=4, channel 2 offers 0x11, 0x22, 0x33, 0x44 with `out_rdy`=1. Required output: 0xA5020000, 0x11, 0x22, 0x33, 0x44. `grant`=4'b0100 during the packet, then IDLE with `seq`=1.
- **Round-robin fairness.** All four channels valid continuously. Headers are 0xA5000000, 0xA5010001, 0xA5020002, 0xA5030003, 0xA5000004. Each is followed by 4 words from the matching channel, and no other channel sees `in_rdy`=1 during a packet.
- **Output backpressure.** Toggle `out_rdy` 1010… during header and data. The header word is held unchanged until accepted, and exactly `BURST` beats are counted, with no duplicate or lost words.
- **Producer stall.** Granted channel 1 drops `in_val` after 2 beats for 5 cycles. `out_val`=0 during the stall, `grant` stays 4'b0010, channel 3 (valid) gets no `in_rdy`, and the burst resumes and completes with the remaining 2 words.
- **Reset mid-burst.** Assert `reset_n`=0 asynchronously after 2 data beats. All outputs go to 0 before the next clock edge. After release, the first header is 0xA5000000 (`seq` and `ptr` cleared).
- **Sequence wrap.** Preload `seq`=0xFFFF (or run 65536 packets with `BURST`=1). Headers read 0xA5xxFFFF, then 0xA5xx0000.
